// File: rtl/uart_pkg.sv
// Shared UART definitions: line format, default divisor inputs and receiver state encoding.
// The emitter imports the same defaults so both ends agree on the bit period.
package uart_pkg;

    localparam int CLK_FREQ_HZ = 12000000;
    localparam int BAUD_RATE   = 9600;
    localparam int DATA_BITS   = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte-delivery handshake and status pulses between the UART receiver and its consumer.
interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_frame_err;
    logic                 o_overrun;

    modport master (output o_data, output o_valid, input i_ready,
                    output o_frame_err, output o_overrun);
    modport slave  (input o_data, input o_valid, output i_ready,
                    input o_frame_err, input o_overrun);
endinterface

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; RST_VAL sets the flush value
// so an idle-high line does not look like an edge coming out of reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: centre-samples each bit off a down-counting baud timer and hands
// bytes out through a one-entry holding buffer, flagging framing errors and overruns.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int clk_freq_hz = CLK_FREQ_HZ,
    parameter int baud_rate   = BAUD_RATE
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_uart_rx,
    uart_receiver_if.master rx_if
);
    localparam int DIV   = baud_div(clk_freq_hz, baud_rate);
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF - 1);

    logic                 rx_s;
    rx_state_t            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 expire;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (i_uart_rx),
        .q   (rx_s)
    );

    assign expire = (baud_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            // Consumption; a same-edge delivery below overrides this clear.
            if (valid_q && rx_if.i_ready)
                valid_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        baud_cnt <= HALF_LD;
                        state    <= START;
                    end
                end
                START: begin
                    if (expire) begin
                        if (!rx_s) begin
                            baud_cnt <= DIV_LD;
                            bit_idx  <= '0;
                            state    <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (expire) begin
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        baud_cnt <= DIV_LD;
                        if (bit_idx == 3'(DATA_BITS - 1))
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (expire) begin
                        if (rx_s) begin
                            if (!valid_q || rx_if.i_ready) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    // Hold off through a break so its trailing low is not taken as a start bit.
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_if.o_data      = data_q;
    assign rx_if.o_valid     = valid_q;
    assign rx_if.o_frame_err = ferr_q;
    assign rx_if.o_overrun   = ovr_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
8N1 UART receiver, the receive-side counterpart of the SOC's UART emitter, feeding the RXD pin into the IO page.
- Synchronises the asynchronous line and detects the start bit.
- Samples each bit at its centre and delivers bytes through a one-entry holding buffer with a valid/ready handshake.
- Flags framing errors and overruns so firmware can poll an IO status word.

Parameters:
clk_freq_hz, 12000000, system clock frequency in Hz
baud_rate, 9600, line rate in bits/s; DIV = clk_freq_hz/baud_rate (truncated, must be >= 4); HALF = DIV/2 (truncated)

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_uart_rx  in  1  asynchronous serial line, idle high
o_data  out  8  received byte; valid while o_valid=1
o_valid  out  1  holding buffer full
i_ready  in  1  consumer accepts o_data when o_valid && i_ready at a clock edge
o_frame_err  out  1  one-cycle pulse: stop bit sampled 0
o_overrun  out  1  one-cycle pulse: a byte completed while the buffer was full and not being consumed

Behaviour:
- Interface: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset state:
  - FSM to IDLE.
  - Both synchroniser flops to 1.
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0.
  - Bit counter and baud counter to 0.
- Reset mid-frame aborts the frame and discards the partial byte.
- Synchroniser: 2 flops; rx_s is i_uart_rx delayed 2 cycles. All FSM decisions use rx_s only.
- Baud counter: width $clog2(DIV). It loads a value and decrements; "expiry" is the cycle it reads 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: if rx_s==0, load HALF-1 and go to START.
  - START: on expiry, if rx_s==0 load DIV-1, clear bit index, go to DATA. If rx_s==1, treat as a glitch and return to IDLE.
  - DATA: on each expiry, shift rx_s into bit 7 of the shift register, shifting right (LSB first on the wire), and reload DIV-1. After the 8th sample go to STOP.
  - STOP: on expiry, if rx_s==1 deliver the byte and go to IDLE. The start edge of the next byte can be detected from the half-stop-bit onward. If rx_s==0, pulse o_frame_err, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers break conditions and prevents false starts.
- Delivery, evaluated in the cycle after the stop sample; register updates are visible the following cycle:
  - Buffer empty, or o_valid && i_ready in the same cycle: load o_data and hold o_valid=1. No overrun.
  - Buffer full and not consumed: keep the old byte, drop the new byte, pulse o_overrun.
- Consumption without delivery: o_valid clears on the edge where o_valid && i_ready.
- Latency: o_valid rises 3 + HALF + 9*DIV cycles (±1) after the i_uart_rx falling edge.
- o_frame_err and o_overrun never assert in the same cycle. Each pulse lasts exactly one cycle.

Decomposition:
- Package uart_pkg:
  - State encoding localparams: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4.
  - DATA_BITS=8.
  - Defaults CLK_FREQ_HZ and BAUD_RATE, shared with the emitter so both ends use the same divisor.
- One sub-module: uart_sync2, a generic 2-flop synchroniser with a reset value parameter (1 here). It is reusable for the RESET button and other asynchronous inputs.

Test Plan:
1. Bench params clk_freq_hz=16, baud_rate=1 (DIV=16, HALF=8). Drive 0x55 8N1 with i_ready=0 -> o_data=0x55; o_valid rises 155±1 cycles after the start edge and holds until i_ready=1 for one cycle, then clears.
2. Glitch: rx low for 3 cycles, then high -> no o_valid and no o_frame_err. A following 0xA3 frame -> o_data=0xA3.
3. 0xFF with stop bit 0, line held low for 40 cycles, then high -> single o_frame_err pulse and o_valid stays 0. Next frame 0x12 -> o_data=0x12.
4. Frames 0x01 then 0x02 back-to-back with i_ready=0 -> o_data stays 0x01, exactly one o_overrun pulse at the second delivery. Then i_ready=1 -> o_valid clears.
5. i_ready asserted exactly in the delivery cycle of a second byte 0x7E (buffer holding 0x01) -> no o_overrun; o_data=0x7E and o_valid remains 1.
6. i_rst pulsed for 1 cycle during data bit 4 of a frame -> all outputs 0 the next cycle, no delivery from the aborted frame. Subsequent 0x3C -> o_data=0x3C.
